rr_grant8: RTL and testbench

- 8-requester round-robin arbiter.
- Produces a registered one-hot grant vector that directly feeds the 8-to-3 one-hot encoder downstream. That encoder converts grant[7:0] into a 3-bit owner index.
- Guarantees grant is always all-zero or exactly one-hot, so the encoder never sees an illegal pattern.
- Holds a grant until the owner releases it or drops its request.

---
 rtl/rr_grant8.sv | 105 ++++++++++
 tb/tb_rr_grant8.sv | 131 +++++++++++++
 2 files changed

// File: rtl/rr_grant8.sv
// rr_grant8: 8-requester round-robin arbiter with a registered, always 0-or-one-hot grant
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset
//   req       in   8  request vector, bit i = requester i
//   release_i in   1  owner finished; ends the current grant
//                     (named release_i because `release` is a reserved word)
//   grant     out  8  registered grant, all-zero or one-hot
//   valid     out  1  registered copy of |grant
//   timeout   out  1  one-cycle pulse on forced release (constant 0 unless
//                     RR_GRANT8_TIMEOUT_EN is defined)
// Parameters: MAX_HOLD (2..255, timeout build only), PTR_INIT (0..7)
module rr_grant8 #(
  parameter int MAX_HOLD = 16,
  parameter int PTR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       release_i,
  output logic [7:0] grant,
  output logic       valid,
  output logic       timeout
);
  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;
  logic       state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] grant_q, grant_d;
  logic       valid_q, valid_d;
  logic [15:0] req_dbl;
  logic [7:0] req_rot;
  logic [2:0] off;
  logic [2:0] win;
  logic [2:0] owner;
  logic       hold;
  logic       force_rel;
  // Rotate so that bit 0 is the requester at ptr; the lowest set bit of the
  // rotated vector is the winner's distance from ptr.
  always_comb begin
    req_dbl = {req, req} >> ptr_q;
    req_rot = req_dbl[7:0];
    off = 3'd0;
    for (int i = 7; i >= 0; i--) off = req_rot[i] ? 3'(i) : off;
    win = ptr_q + off;
  end
  always_comb begin
    owner = 3'd0;
    for (int i = 0; i < 8; i++) owner = grant_q[i] ? 3'(i) : owner;
    hold = |(req & grant_q) & ~release_i;
  end
`ifdef RR_GRANT8_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
  // A forced release only happens when the owner would otherwise keep the
  // grant, so a normal release in the same cycle never pulses timeout.
  assign force_rel = (state_q == BUSY) && hold && (cnt_q == 8'(MAX_HOLD - 1));
  always_comb begin
    cnt_d = (state_q == IDLE) ? 8'd0 : cnt_q + 8'd1;
    timeout_d = force_rel;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    if (state_q == IDLE) begin
      state_d = |req ? BUSY : IDLE;
      grant_d = |req ? 8'b1 << win : 8'h00;
    end else if (!hold || force_rel) begin
      state_d = IDLE;
      grant_d = 8'h00;
      ptr_d = owner + 3'd1;
    end
    valid_d = |grant_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= 3'(PTR_INIT);
      grant_q <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end
  assign grant = grant_q;
  assign valid = valid_q;
endmodule

// File: tb/tb_rr_grant8.sv
// tb_rr_grant8: directed self-checking bench for rr_grant8
module tb_rr_grant8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'hFF;
  logic       release_i = 1'b0;
  logic [7:0] grant;
  logic       valid;
  logic       timeout;
  int n_chk = 0;
  int n_fail = 0;
  rr_grant8 #(.MAX_HOLD(4), .PTR_INIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .release_i(release_i),
    .grant(grant), .valid(valid), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_g(input string tag, input logic [7:0] exp);
    chk({tag, ".grant"}, grant, exp);
    chk({tag, ".valid"}, valid, |exp);
  endtask
  always @(negedge clk) if (rst_n) chk("onehot0", $onehot0(grant), 1);
  initial begin
    int bad;
    tick();
    tick();
    chk_g("reset", 8'h00);
    chk("reset.timeout", timeout, 0);
    rst_n = 1'b1;
    tick();
    chk_g("first", 8'h01);
    for (int i = 0; i < 8; i++) begin
      release_i = 1'b1;
      tick();
      chk_g($sformatf("rot_idle%0d", i), 8'h00);
      release_i = 1'b0;
      tick();
      chk_g($sformatf("rot_grant%0d", i), 8'h01 << ((i + 1) % 8));
    end
    tick();
    chk_g("hold", 8'h01);
    req = 8'h40;
    release_i = 1'b1;
    tick();
    release_i = 1'b0;
    tick();
    chk_g("own6", 8'h40);
    req = 8'h0A;
    release_i = 1'b1;
    tick();
    chk_g("rel6", 8'h00);
    release_i = 1'b0;
    tick();
    chk_g("wrap", 8'h02);
    release_i = 1'b1;
    tick();
    release_i = 1'b0;
    tick();
    chk_g("sparse", 8'h08);
    req = 8'h04;
    release_i = 1'b1;
    tick();
    release_i = 1'b0;
    tick();
    chk_g("own2", 8'h04);
    tick();
    chk_g("own2_hold", 8'h04);
    req = 8'h00;
    tick();
    chk_g("drop", 8'h00);
    tick();
    chk_g("idle_norq", 8'h00);
    req = 8'h0C;
    release_i = 1'b1;
    tick();
    chk_g("ptr3_rel_idle", 8'h08);
    req = 8'h10;
    tick();
    release_i = 1'b0;
    tick();
    chk_g("own4", 8'h10);
    #2 rst_n = 1'b0;
    #1;
    chk_g("async_rst", 8'h00);
    req = 8'h11;
    tick();
    rst_n = 1'b1;
    chk_g("rst_hold", 8'h00);
    tick();
    chk_g("ptr_init", 8'h01);
    req = 8'h01;
    release_i = 1'b1;
    tick();
    release_i = 1'b0;
    tick();
    chk_g("to_grant", 8'h01);
`ifdef RR_GRANT8_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_g($sformatf("to_hold%0d", i), 8'h01);
      chk("to_nopulse", timeout, 0);
    end
    tick();
    chk_g("to_forced", 8'h00);
    chk("to_pulse", timeout, 1);
    tick();
    chk_g("to_regrant", 8'h01);
    chk("to_pulse_end", timeout, 0);
`else
    bad = 0;
    for (int i = 0; i < 110; i++) begin
      tick();
      if (grant !== 8'h01 || timeout !== 1'b0) bad++;
    end
    chk("hold_forever", bad, 0);
    chk("timeout_zero", timeout, 0);
`endif
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
